// File: rtl/rv_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package rv_boot_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned WORD_W        = 32;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned RELEASE_DELAY = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT,
      ST_DATA,
      ST_DONE,
      ST_ERROR
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // Drop one byte into its little-endian lane of a 32-bit word.
   function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx,
                                                  input logic [BYTE_W-1:0] b);
      logic [WORD_W-1:0] w;
      w = word;
      w[{idx, 3'b000} +: BYTE_W] = b;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchroniser; one-cycle byte and framing-error pulses.
module uart_rx
   import rv_boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_byte_valid,
   output logic [7:0] o_byte_data,
   output logic       o_frame_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   logic             r_rx_meta;
   logic             r_rx_sync;
   logic             r_rx_prev;
   rx_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_byte_valid;
   logic [7:0]       r_byte_data;
   logic             r_frame_err;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Receive FSM: confirm start at half bit, then sample every full bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RX_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         unique case (r_state)
            RX_IDLE: begin
               if (r_rx_prev && !r_rx_sync) begin
                  r_state <= RX_START;
                  r_cnt   <= '0;
               end
            end
            RX_START: begin
               if (r_cnt == HALF_LAST) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (r_cnt == FULL_LAST) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     r_state <= RX_STOP;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (r_cnt == FULL_LAST) begin
                  r_cnt   <= '0;
                  r_state <= RX_IDLE;
                  if (r_rx_sync) begin
                     r_byte_valid <= 1'b1;
                     r_byte_data  <= r_shift;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign o_byte_valid = r_byte_valid;
   assign o_byte_data  = r_byte_data;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: fills instruction memory from a UART image, then releases core reset.
module imem_uart_loader
   import rv_boot_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned IDX_W        = ADDR_WIDTH + 1;
   localparam int unsigned REL_W        = $clog2(RELEASE_DELAY + 1);
   localparam logic [32:0] DEPTH        = 33'(1) << ADDR_WIDTH;
   localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DELAY - 1);

   logic                  w_byte_valid;
   logic [7:0]            w_byte_data;
   logic                  w_frame_err;
   logic [31:0]           w_full_word;
   logic [IDX_W-1:0]      w_idx_next;
   logic                  w_last_word;

   loader_state_e         r_state;
   logic [1:0]            r_byte_idx;
   logic [31:0]           r_word;
   logic [31:0]           r_count;
   logic [IDX_W-1:0]      r_word_idx;
   logic [REL_W-1:0]      r_rel_cnt;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_wdata;
   logic                  r_core_rst_n;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rx         (rx),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err)
   );

   // Word under assembly with the incoming byte merged in, and end-of-image test.
   assign w_full_word = put_byte(r_word, r_byte_idx, w_byte_data);
   assign w_idx_next  = r_word_idx + IDX_W'(1);
   assign w_last_word = (32'(w_idx_next) == r_count);

   // Loader FSM: sync, count, data words, then terminal DONE or ERROR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_byte_idx   <= '0;
         r_word       <= '0;
         r_count      <= '0;
         r_word_idx   <= '0;
         r_rel_cnt    <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_core_rst_n <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_byte_valid && (w_byte_data == SYNC_BYTE)) begin
                  r_state    <= ST_CNT;
                  r_busy     <= 1'b1;
                  r_byte_idx <= '0;
                  r_word_idx <= '0;
               end
            end
            ST_CNT: begin
               if (w_frame_err) begin
                  r_state <= ST_ERROR;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else if (w_byte_valid) begin
                  r_word     <= w_full_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_count <= w_full_word;
                     if ({1'b0, w_full_word} > DEPTH) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                     end else if (w_full_word == 32'd0) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rel_cnt <= '0;
                     end else begin
                        r_state <= ST_DATA;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (w_frame_err) begin
                  r_state <= ST_ERROR;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else if (w_byte_valid) begin
                  r_word     <= w_full_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                     r_imem_wdata <= w_full_word;
                     r_word_idx   <= w_idx_next;
                     if (w_last_word) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rel_cnt <= '0;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (r_rel_cnt == REL_LAST) begin
                  r_core_rst_n <= 1'b1;
               end else begin
                  r_rel_cnt <= r_rel_cnt + REL_W'(1);
               end
            end
            ST_ERROR: begin
               r_core_rst_n <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_rst_n = r_core_rst_n;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: full-size and 4-word instances share one rx line.
module tb_imem_uart_loader;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 6_250_000;
   localparam int unsigned CPB      = CLK_FREQ / BAUD;
   localparam int          NV       = 7;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [4:0]        nbytes;
      logic [23:0][7:0]  bytes;
      logic [4:0]        bad_at;
      logic [2:0]        nwr;
      logic [3:0][31:0]  words;
      logic              b_done;
      logic              b_err;
      logic              b_busy;
      logic              s_done;
      logic              s_err;
      logic              s_busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;

   logic        b_we, b_crst, b_busy, b_done, b_err;
   logic [9:0]  b_addr;
   logic [31:0] b_wdata;
   logic        s_we, s_crst, s_busy, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cur_vec  = -1;
   int          cyc      = 0;
   int          t_done   = -1;
   int          t_rel    = -1;
   logic        done_q   = 1'b0;
   logic        crst_q   = 1'b0;
   wr_t         q_big[$];
   wr_t         q_small[$];
   vec_t        vecs[NV];

   always #5 clk = ~clk;

   imem_uart_loader #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .ADDR_WIDTH (10),
      .SYNC_BYTE  (8'hA5)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .imem_we    (b_we),
      .imem_addr  (b_addr),
      .imem_wdata (b_wdata),
      .core_rst_n (b_crst),
      .busy       (b_busy),
      .done       (b_done),
      .err        (b_err)
   );

   imem_uart_loader #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .ADDR_WIDTH (2),
      .SYNC_BYTE  (8'hA5)
   ) u_dut_small (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .imem_we    (s_we),
      .imem_addr  (s_addr),
      .imem_wdata (s_wdata),
      .core_rst_n (s_crst),
      .busy       (s_busy),
      .done       (s_done),
      .err        (s_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
      end
   endtask

   // Scoreboard: every write is popped against the expected queue; release timing tracked.
   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (!rst_n) begin
         t_done = -1;
         t_rel  = -1;
      end else begin
         if (b_done && !done_q) t_done = cyc;
         if (b_crst && !crst_q) t_rel = cyc;
      end
      done_q = b_done;
      crst_q = b_crst;
      if (b_we) begin
         if (q_big.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL big_unexpected_write (vec %0d): addr %h data %h", cur_vec, b_addr, b_wdata);
         end else begin
            e = q_big.pop_front();
            check("big_addr", 32'(b_addr), 32'(e.addr));
            check("big_data", b_wdata, e.data);
         end
      end
      if (s_we) begin
         if (q_small.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL small_unexpected_write (vec %0d): addr %h data %h", cur_vec, s_addr, s_wdata);
         end else begin
            e = q_small.pop_front();
            check("small_addr", 32'(s_addr), 32'(e.addr));
            check("small_data", s_wdata, e.data);
         end
      end
   end

   function automatic vec_t add_b(input vec_t v, input logic [7:0] b);
      vec_t r;
      r = v;
      r.bytes[r.nbytes] = b;
      r.nbytes = r.nbytes + 5'd1;
      return r;
   endfunction

   function automatic vec_t add_w(input vec_t v, input logic [31:0] w);
      vec_t r;
      r = v;
      for (int k = 0; k < 4; k++) r = add_b(r, w[8*k +: 8]);
      return r;
   endfunction

   function automatic vec_t add_data(input vec_t v, input logic [31:0] w);
      vec_t r;
      r = add_w(v, w);
      r.words[r.nwr] = w;
      r.nwr = r.nwr + 3'd1;
      return r;
   endfunction

   function automatic vec_t new_vec(input logic bd, input logic be, input logic bb,
                                    input logic sd, input logic se, input logic sb);
      vec_t r;
      r = '0;
      r.bad_at = 5'd31;
      r.b_done = bd; r.b_err = be; r.b_busy = bb;
      r.s_done = sd; r.s_err = se; r.s_busy = sb;
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2*CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic push_exp(input logic [9:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      q_big.push_back(e);
      q_small.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_b_we"},    32'(b_we),    32'd0);
      check({tag, "_b_addr"},  32'(b_addr),  32'd0);
      check({tag, "_b_wdata"}, b_wdata,      32'd0);
      check({tag, "_b_crst"},  32'(b_crst),  32'd0);
      check({tag, "_b_busy"},  32'(b_busy),  32'd0);
      check({tag, "_b_done"},  32'(b_done),  32'd0);
      check({tag, "_b_err"},   32'(b_err),   32'd0);
      check({tag, "_s_crst"},  32'(s_crst),  32'd0);
      check({tag, "_s_busy"},  32'(s_busy),  32'd0);
      check({tag, "_s_done"},  32'(s_done),  32'd0);
      check({tag, "_s_err"},   32'(s_err),   32'd0);
   endtask

   initial begin
      vec_t v;

      // Vector table: byte stream, expected writes, final status of both instances.
      v = new_vec(1, 0, 0, 1, 0, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd2);
      v = add_data(v, 32'h0000_0013); v = add_data(v, 32'h0020_00B3);
      vecs[0] = v;

      v = new_vec(1, 0, 0, 1, 0, 0);
      v = add_b(v, 8'h00); v = add_b(v, 8'hFF); v = add_b(v, 8'h5A);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd1); v = add_data(v, 32'hDEAD_BEEF);
      vecs[1] = v;

      v = new_vec(0, 1, 0, 0, 1, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd1025);
      vecs[2] = v;

      v = new_vec(0, 1, 0, 0, 1, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd1);
      v = add_b(v, 8'h13); v = add_b(v, 8'h00); v = add_b(v, 8'h00);
      v.bad_at = 5'd7;
      vecs[3] = v;

      v = new_vec(1, 0, 0, 1, 0, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd0);
      vecs[4] = v;

      v = new_vec(1, 0, 0, 1, 0, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd4);
      v = add_data(v, 32'h1111_0001); v = add_data(v, 32'h2222_0002);
      v = add_data(v, 32'h3333_0003); v = add_data(v, 32'hCAFE_F00D);
      vecs[5] = v;

      v = new_vec(0, 0, 1, 0, 1, 0);
      v = add_b(v, 8'hA5); v = add_w(v, 32'd5);
      vecs[6] = v;

      // Reset state, then 100 us of idle line.
      rst_n = 1'b0;
      rx    = 1'b1;
      #20;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10000) @(negedge clk);
      check_idle_outputs("idle");

      for (int i = 0; i < NV; i++) begin
         cur_vec = i;
         do_reset();
         for (int k = 0; k < int'(vecs[i].nwr); k++) push_exp(10'(k), vecs[i].words[k]);
         for (int j = 0; j < int'(vecs[i].nbytes); j++)
            send_byte(vecs[i].bytes[j], (j == int'(vecs[i].bad_at)) ? 1'b0 : 1'b1);
         repeat (4*CPB) @(negedge clk);
         check("b_done", 32'(b_done), 32'(vecs[i].b_done));
         check("b_err",  32'(b_err),  32'(vecs[i].b_err));
         check("b_busy", 32'(b_busy), 32'(vecs[i].b_busy));
         check("b_crst", 32'(b_crst), 32'(vecs[i].b_done));
         check("s_done", 32'(s_done), 32'(vecs[i].s_done));
         check("s_err",  32'(s_err),  32'(vecs[i].s_err));
         check("s_busy", 32'(s_busy), 32'(vecs[i].s_busy));
         check("s_crst", 32'(s_crst), 32'(vecs[i].s_done));
         check("b_pending_writes", 32'(q_big.size()), 32'd0);
         check("s_pending_writes", 32'(q_small.size()), 32'd0);
         if (vecs[i].b_done) check("release_delay", 32'(t_rel - t_done), 32'd2);
         q_big.delete();
         q_small.delete();
      end

      // Reset mid-load after two data bytes, with a short glitch first; then a clean image.
      cur_vec = 100;
      do_reset();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2*CPB) @(negedge clk);
      send_byte(8'hA5, 1'b1);
      send_word(32'd1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      check("midload_busy_before_reset", 32'(b_busy), 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midload_busy_in_reset", 32'(b_busy), 32'd0);
      check("midload_crst_in_reset", 32'(b_crst), 32'd0);
      check("midload_done_in_reset", 32'(b_done), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      push_exp(10'd0, 32'h0010_0093);
      send_byte(8'hA5, 1'b1);
      send_word(32'd1);
      send_word(32'h0010_0093);
      repeat (4*CPB) @(negedge clk);
      check("midload_b_done", 32'(b_done), 32'd1);
      check("midload_b_crst", 32'(b_crst), 32'd1);
      check("midload_s_done", 32'(s_done), 32'd1);
      check("midload_b_pending", 32'(q_big.size()), 32'd0);
      check("midload_s_pending", 32'(q_small.size()), 32'd0);

      // Traffic after DONE must be ignored.
      send_byte(8'hA5, 1'b1);
      send_word(32'd1);
      send_word(32'h1234_5678);
      repeat (4*CPB) @(negedge clk);
      check("post_done_busy", 32'(b_busy), 32'd0);
      check("post_done_done", 32'(b_done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
